instruction_memory_loadable: RTL and testbench

Parametrised successor to the fetch-stage instruction memory. It is a synchronous-read instruction store with pipeline stall/flush control and a valid flag. A byte-serial program loader writes words at run time, so programs no longer have to be baked in at elaboration. It sits between the PC register and the IF/ID pipeline register.

---
 rtl/instruction_memory_loadable_if.sv | 32 +++
 rtl/instruction_memory_loadable.sv | 133 +++++++++++++
 tb/tb_instruction_memory_loadable.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_loadable_if.sv
// Fetch and byte-serial loader signals of the loadable instruction memory.
// The master drives addresses, control and load bytes; the slave returns the fetched word and status.
interface instruction_memory_loadable_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] Endereco;
  logic                  Le;
  logic                  Stall;
  logic                  Flush;
  logic [DATA_WIDTH-1:0] Saida;
  logic                  Valida;
  logic                  Carga_Inicio;
  logic [ADDR_WIDTH-1:0] Carga_Endereco;
  logic [7:0]            Carga_Byte;
  logic                  Carga_Valido;
  logic                  Carga_Fim;
  logic                  Carga_Pronto;
  logic                  Ocupado;

  modport master (
    output Endereco, Le, Stall, Flush,
    output Carga_Inicio, Carga_Endereco, Carga_Byte, Carga_Valido, Carga_Fim,
    input  Saida, Valida, Carga_Pronto, Ocupado
  );

  modport slave (
    input  Endereco, Le, Stall, Flush,
    input  Carga_Inicio, Carga_Endereco, Carga_Byte, Carga_Valido, Carga_Fim,
    output Saida, Valida, Carga_Pronto, Ocupado
  );
endinterface

// File: rtl/instruction_memory_loadable.sv
// Synchronous-read instruction store with stall/flush and a valid flag,
// plus a byte-serial loader that assembles big-endian words and writes them at run time.
module instruction_memory_loadable #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] BOLHA      = DATA_WIDTH'(32'h1FDEF2A4)
) (
  input logic                    Clk,
  input logic                    Rst_n,
  instruction_memory_loadable_if.slave bus
);

  localparam int                    BYTES   = DATA_WIDTH / 8;
  localparam int                    CNT_W   = $clog2(BYTES + 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {OCIOSO, RECEBE, ESCREVE} estado_t;

  estado_t               estado, proximo;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] palavra;
  logic [DATA_WIDTH-1:0] byte_pos;
  logic [CNT_W-1:0]      cnt, cnt_inc;
  logic                  ultimo;
  logic                  ocupado, pronto;
  logic [DATA_WIDTH-1:0] saida_p1;
  logic                  valida_p1;

  function automatic logic [ADDR_WIDTH-1:0] ptr_mod(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] r;
    r = {1'b0, a} % DEPTH_L;
    return r[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_A) ? '0 : p + 1'b1;
  endfunction

  assign cnt_inc  = cnt + 1'b1;
  // The first byte of a word lands in the top byte; later bytes move down.
  assign byte_pos = {bus.Carga_Byte, {(DATA_WIDTH-8){1'b0}}} >> {cnt, 3'b000};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) estado <= OCIOSO;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    ocupado = 1'b0;
    pronto  = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.Carga_Inicio) proximo = RECEBE;
      end
      RECEBE: begin
        ocupado = 1'b1;
        pronto  = 1'b1;
        if (bus.Carga_Valido && (cnt_inc == CNT_W'(BYTES) || bus.Carga_Fim)) proximo = ESCREVE;
      end
      ESCREVE: begin
        ocupado = 1'b1;
        proximo = ultimo ? OCIOSO : RECEBE;
      end
      default: proximo = OCIOSO;
    endcase
  end

  assign bus.Ocupado      = ocupado;
  assign bus.Carga_Pronto = pronto;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt    <= '0;
      ultimo <= 1'b0;
    end else begin
      case (estado)
        OCIOSO:  if (bus.Carga_Inicio) begin cnt <= '0; ultimo <= 1'b0; end
        RECEBE:  if (bus.Carga_Valido) begin cnt <= cnt_inc; ultimo <= bus.Carga_Fim; end
        ESCREVE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Word assembly and array write; a reset mid-load leaves written words intact.
  always_ff @(posedge Clk) begin
    case (estado)
      OCIOSO: begin
        if (bus.Carga_Inicio) begin
          ptr     <= ptr_mod(bus.Carga_Endereco);
          palavra <= '0;
        end
      end
      RECEBE: begin
        if (bus.Carga_Valido) palavra <= palavra | byte_pos;
      end
      ESCREVE: begin
        mem[ptr] <= palavra;
        ptr      <= ptr_inc(ptr);
        palavra  <= '0;
      end
      default: ;
    endcase
  end

  // Fetch stage p0 -> p1: registered read toward the IF/ID register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      saida_p1  <= BOLHA;
      valida_p1 <= 1'b0;
    end else if (ocupado || bus.Flush) begin
      saida_p1  <= BOLHA;
      valida_p1 <= 1'b0;
    end else if (bus.Stall) begin
      saida_p1  <= saida_p1;
      valida_p1 <= valida_p1;
    end else if (bus.Le) begin
      saida_p1  <= ({1'b0, bus.Endereco} < DEPTH_L) ? mem[bus.Endereco] : BOLHA;
      valida_p1 <= 1'b1;
    end else begin
      saida_p1  <= BOLHA;
      valida_p1 <= 1'b0;
    end
  end

  assign bus.Saida  = saida_p1;
  assign bus.Valida = valida_p1;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Randomized bench for instruction_memory_loadable against an array/flag reference model,
// with literal expectations for the documented fetch, load, wrap, stall/flush and reset cases.
module tb_instruction_memory_loadable;

  localparam int          DW     = 32;
  localparam int          AW     = 10;
  localparam int          DEPTH  = 1024;
  localparam int          DEPTH2 = 1000;
  localparam logic [31:0] BOLHA  = 32'h1FDEF2A4;

  logic Clk;
  logic Rst_n;

  instruction_memory_loadable_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();
  instruction_memory_loadable_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc2 ();

  instruction_memory_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BOLHA(BOLHA)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(ifc)
  );

  instruction_memory_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH2), .BOLHA(BOLHA)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(ifc2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_mem [0:DEPTH-1];
  bit          m_busy;
  logic [31:0] exp_s;
  logic        exp_v;
  bit          chk_en, rand_fetch, noise;
  logic [7:0]  lb [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: what the registered fetch output must be after each rising edge.
  always @(posedge Clk) begin
    if (!Rst_n) begin
      exp_s = BOLHA; exp_v = 1'b0;
    end else if (m_busy || ifc.Flush) begin
      exp_s = BOLHA; exp_v = 1'b0;
    end else if (ifc.Stall) begin
      exp_s = exp_s; exp_v = exp_v;
    end else if (ifc.Le) begin
      exp_s = (int'(ifc.Endereco) >= DEPTH) ? BOLHA : m_mem[ifc.Endereco];
      exp_v = 1'b1;
    end else begin
      exp_s = BOLHA; exp_v = 1'b0;
    end
    #1;
    if (chk_en) begin
      check("saida_cycle", ifc.Saida, exp_s);
      check("valida_cycle", 32'(ifc.Valida), 32'(exp_v));
    end
  end

  always @(negedge Clk) begin
    if (rand_fetch) begin
      ifc.Le       = ($urandom_range(0, 3) != 0);
      ifc.Endereco = AW'($urandom_range(0, DEPTH - 1));
      ifc.Stall    = ($urandom_range(0, 5) == 0);
      ifc.Flush    = ($urandom_range(0, 7) == 0);
    end
    if (noise) begin
      ifc.Carga_Valido = 1'($urandom_range(0, 1));
      ifc.Carga_Byte   = 8'($urandom);
      ifc.Carga_Fim    = 1'($urandom_range(0, 1));
    end
  end

  task automatic load(input logic [AW-1:0] base, input int n);
    int          ptr, k, gaps;
    logic [31:0] w;
    noise = 1'b0;
    @(negedge Clk);
    ifc.Carga_Valido = 1'b0; ifc.Carga_Fim = 1'b0;
    ifc.Carga_Inicio = 1'b1; ifc.Carga_Endereco = base;
    @(negedge Clk);
    ifc.Carga_Inicio = 1'b0;
    m_busy = 1'b1;
    check("busy_start", 32'(ifc.Ocupado), 32'd1);
    ptr = int'(base) % DEPTH; k = 0; w = '0;
    for (int i = 0; i < n; i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        ifc.Carga_Fim      = 1'($urandom_range(0, 1));
        ifc.Carga_Inicio   = 1'($urandom_range(0, 1));
        ifc.Carga_Endereco = AW'($urandom);
        ifc.Carga_Byte     = 8'($urandom);
        @(negedge Clk);
      end
      ifc.Carga_Inicio = 1'b0;
      ifc.Carga_Valido = 1'b1;
      ifc.Carga_Byte   = lb[i];
      ifc.Carga_Fim    = (i == n - 1);
      check("pronto_byte", 32'(ifc.Carga_Pronto), 32'd1);
      w = w | (32'(lb[i]) << (8 * (3 - k)));
      @(negedge Clk);
      ifc.Carga_Valido = 1'b0; ifc.Carga_Fim = 1'b0;
      if (k == 3 || i == n - 1) begin
        check("pronto_write", 32'(ifc.Carga_Pronto), 32'd0);
        check("busy_write", 32'(ifc.Ocupado), 32'd1);
        m_mem[ptr] = w;
        ptr = (ptr + 1) % DEPTH; k = 0; w = '0;
        @(negedge Clk);
        if (i == n - 1) begin
          check("busy_end", 32'(ifc.Ocupado), 32'd0);
          m_busy = 1'b0;
        end else begin
          check("pronto_resume", 32'(ifc.Carga_Pronto), 32'd1);
        end
      end else begin
        k++;
      end
    end
  endtask

  task automatic fetch_lit(input logic [AW-1:0] a, input logic [31:0] e, input string nm);
    @(negedge Clk);
    ifc.Le = 1'b1; ifc.Endereco = a; ifc.Stall = 1'b0; ifc.Flush = 1'b0;
    @(posedge Clk); #1;
    check(nm, ifc.Saida, e);
    check({nm, "_valida"}, 32'(ifc.Valida), 32'd1);
  endtask

  task automatic set_bytes(input logic [31:0] hi, input logic [31:0] lo);
    for (int i = 0; i < 4; i++) begin
      lb[i]     = hi[31 - 8 * i -: 8];
      lb[i + 4] = lo[31 - 8 * i -: 8];
    end
  endtask

  initial begin
    Rst_n = 1'b1;
    {ifc.Le, ifc.Stall, ifc.Flush, ifc.Carga_Inicio, ifc.Carga_Valido, ifc.Carga_Fim} = '0;
    ifc.Endereco = '0; ifc.Carga_Endereco = '0; ifc.Carga_Byte = '0;
    {ifc2.Le, ifc2.Stall, ifc2.Flush, ifc2.Carga_Inicio, ifc2.Carga_Valido, ifc2.Carga_Fim} = '0;
    ifc2.Endereco = '0; ifc2.Carga_Endereco = '0; ifc2.Carga_Byte = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 1'b0; exp_s = BOLHA; exp_v = 1'b0;
    chk_en = 1'b0; rand_fetch = 1'b0; noise = 1'b0;

    #1 Rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge Clk);
    check("rst_saida", ifc.Saida, BOLHA);
    check("rst_valida", 32'(ifc.Valida), 32'd0);
    check("rst_ocupado", 32'(ifc.Ocupado), 32'd0);
    check("rst_pronto", 32'(ifc.Carga_Pronto), 32'd0);
    Rst_n = 1'b1;

    for (int a = 0; a < 4; a++) fetch_lit(AW'(a), 32'h0, "init_zero");

    set_bytes(32'h201F1500, 32'hAABBCCDD);
    load(AW'(5), 8);
    fetch_lit(AW'(5), 32'h201F1500, "load_w5");
    fetch_lit(AW'(6), 32'hAABBCCDD, "load_w6");

    set_bytes(32'h01020304, 32'h05060708);
    load(AW'(DEPTH - 1), 8);
    fetch_lit(AW'(DEPTH - 1), 32'h01020304, "wrap_last");
    fetch_lit(AW'(0), 32'h05060708, "wrap_zero");

    lb[0] = 8'h11; lb[1] = 8'h22;
    load(AW'(40), 2);
    fetch_lit(AW'(40), 32'h11220000, "partial");

    fetch_lit(AW'(5), 32'h201F1500, "pre_stall");
    for (int s = 0; s < 3; s++) begin
      @(negedge Clk);
      ifc.Stall = 1'b1; ifc.Le = 1'b1; ifc.Endereco = AW'(100 + s);
      @(posedge Clk); #1;
      check("stall_saida", ifc.Saida, 32'h201F1500);
      check("stall_valida", 32'(ifc.Valida), 32'd1);
    end
    @(negedge Clk);
    ifc.Flush = 1'b1; ifc.Stall = 1'b1;
    @(posedge Clk); #1;
    check("flush_saida", ifc.Saida, BOLHA);
    check("flush_valida", 32'(ifc.Valida), 32'd0);

    set_bytes(32'hCAFEBABE, 32'h0);
    load(AW'(9), 4);
    fetch_lit(AW'(9), 32'hCAFEBABE, "pre_reset_w9");
    @(negedge Clk);
    ifc.Carga_Inicio = 1'b1; ifc.Carga_Endereco = AW'(9);
    @(negedge Clk);
    ifc.Carga_Inicio = 1'b0; m_busy = 1'b1;
    ifc.Carga_Valido = 1'b1; ifc.Carga_Byte = 8'h12;
    @(negedge Clk);
    ifc.Carga_Byte = 8'h34;
    @(negedge Clk);
    ifc.Carga_Valido = 1'b0;
    Rst_n = 1'b0; m_busy = 1'b0;
    #1;
    check("midload_ocupado", 32'(ifc.Ocupado), 32'd0);
    check("midload_saida", ifc.Saida, BOLHA);
    @(negedge Clk);
    Rst_n = 1'b1;
    fetch_lit(AW'(9), 32'hCAFEBABE, "kept_w9");
    lb[0] = 8'h77;
    load(AW'(12), 1);
    fetch_lit(AW'(12), 32'h77000000, "fresh_after_reset");

    @(negedge Clk);
    ifc2.Le = 1'b1; ifc2.Endereco = AW'(1010);
    @(posedge Clk); #1;
    check("oor_saida", ifc2.Saida, BOLHA);
    check("oor_valida", 32'(ifc2.Valida), 32'd1);
    @(negedge Clk);
    ifc2.Endereco = AW'(DEPTH2 - 1);
    @(posedge Clk); #1;
    check("inrange_saida", ifc2.Saida, 32'h0);
    check("inrange_valida", 32'(ifc2.Valida), 32'd1);

    rand_fetch = 1'b1;
    for (int s = 0; s < 25; s++) begin
      int n;
      logic [AW-1:0] base;
      noise = 1'b1;
      repeat ($urandom_range(5, 30)) @(negedge Clk);
      noise = 1'b0;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) lb[i] = 8'($urandom);
      base = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1 - $urandom_range(0, 2)) : AW'($urandom_range(0, 63));
      load(base, n);
    end
    rand_fetch = 1'b0;
    noise = 1'b0;
    @(negedge Clk);
    ifc.Carga_Valido = 1'b0; ifc.Carga_Fim = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge Clk);
      ifc.Le = 1'b1; ifc.Stall = 1'b0; ifc.Flush = 1'b0; ifc.Endereco = AW'(a);
    end
    @(negedge Clk);
    ifc.Le = 1'b0;
    repeat (2) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
